// File: rtl/tape_vga_server_if.sv
// CPU tape port bundle: the core (master) issues writes and held read requests,
// the tape server (slave) answers with a one-cycle rvalid and holds off via cpu_ready.
interface tape_vga_server_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_ready;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cpu_rdata, cpu_rvalid, cpu_ready
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cpu_rdata, cpu_rvalid, cpu_ready
    );
endinterface

// File: rtl/tape_vga_server.sv
// Tape cell RAM shared by VGA scan-out and the CPU: one write port, one registered
// read port arbitrated VGA-first, plus a zeroing sweep after every reset.
module tape_vga_server #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    vga_data_addr,
    output logic [7:0]           vga_cell,
    tape_vga_server_if.slave     cpu
);
    localparam int DATA_W = 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   last_vga_addr_q;
    logic                vga_pending_q;
    logic                clearing;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                vga_slot, cpu_slot, vga_hit;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   cpu_rdata_p1;
    logic                vld_p1;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < $unsigned(DEPTH));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= CLEAR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && ptr_q == LAST_PTR) state_d = RUN;
    end

    always_comb begin
        clearing      = (state_q == CLEAR);
        cpu.cpu_ready = (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset)         ptr_q <= '0;
        else if (clearing) ptr_q <= ptr_q + 1'b1;
    end

    // Stage p0: write select, read-port arbitration and write-first bypass
    always_comb begin
        wr_en   = !reset && (clearing || (cpu.cpu_we && in_range(cpu.cpu_addr)));
        wr_addr = clearing ? ptr_q : cpu.cpu_addr;
        wr_data = clearing ? '0 : cpu.cpu_wdata;

        vga_slot = !reset && (vga_pending_q || (vga_data_addr != last_vga_addr_q));
        cpu_slot = !reset && !clearing && !vga_slot && cpu.cpu_re && !vld_p1;
        vga_hit  = wr_en && !vga_slot && (wr_addr == last_vga_addr_q);

        rd_addr = vga_slot ? vga_data_addr : cpu.cpu_addr;
        // The whole tape reads as zero until the sweep finishes.
        if (clearing || !in_range(rd_addr))
            rd_word = '0;
        else if (wr_en && wr_addr == rd_addr)
            rd_word = wr_data;
        else
            rd_word = mem[rd_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // Stage p1: registered read results and read bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_pending_q   <= 1'b1;
            last_vga_addr_q <= '1;
            vld_p1          <= 1'b0;
        end else begin
            vld_p1 <= cpu_slot;
            if (vga_slot) begin
                vga_pending_q   <= 1'b0;
                last_vga_addr_q <= vga_data_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_cell     <= '0;
            cpu_rdata_p1 <= '0;
        end else begin
            if (vga_slot)     vga_cell <= rd_word;
            else if (vga_hit) vga_cell <= wr_data;
            if (cpu_slot) cpu_rdata_p1 <= rd_word;
        end
    end

    assign cpu.cpu_rdata  = cpu_rdata_p1;
    assign cpu.cpu_rvalid = vld_p1;
endmodule

// File: tb/tb_tape_vga_server.sv
// Directed bench for tape_vga_server with a 64-cell tape: clear sweep, CPU
// read/write, VGA latency and coherence, starvation bound and mid-run reset.
module tb_tape_vga_server;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] vga_data_addr = '0;
    logic [7:0]        vga_cell;

    int n_cmp = 0;
    int n_bad = 0;

    tape_vga_server_if #(.ADDR_W(ADDR_W)) cpu_bus ();

    tape_vga_server #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .vga_data_addr (vga_data_addr),
        .vga_cell      (vga_cell),
        .cpu           (cpu_bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        cpu_bus.cpu_addr  = a;
        cpu_bus.cpu_wdata = d;
        cpu_bus.cpu_we    = 1'b1;
        step();
        cpu_bus.cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [7:0] d, output int lat);
        cpu_bus.cpu_addr = a;
        cpu_bus.cpu_re   = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!cpu_bus.cpu_rvalid && lat < 10);
        chk("rd_rvalid_seen", 32'(cpu_bus.cpu_rvalid), 32'd1);
        d = cpu_bus.cpu_rdata;
        cpu_bus.cpu_re = 1'b0;
    endtask

    task automatic wait_clear(input string tag, output int n, output int rv);
        n  = 0;
        rv = 0;
        while (!cpu_bus.cpu_ready && n < 200) begin
            step();
            n++;
            if (cpu_bus.cpu_rvalid) rv++;
        end
        chk(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        logic [7:0] d;
        int lat, n, rv;
        logic [7:0] exp_seq [3];

        exp_seq[0] = 8'h10; exp_seq[1] = 8'h20; exp_seq[2] = 8'h30;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_re    = 1'b0;
        vga_data_addr     = 14'h003F;

        // Power-up reset and clear sweep
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_vga_cell", 32'(vga_cell), 32'h0);
        chk("rst_rvalid",   32'(cpu_bus.cpu_rvalid), 32'h0);
        chk("rst_ready",    32'(cpu_bus.cpu_ready), 32'h0);
        chk("rst_rdata",    32'(cpu_bus.cpu_rdata), 32'h0);
        wait_clear("clear_cycles", n, rv);
        chk("vga_cell_after_clear", 32'(vga_cell), 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            cpu_read(ADDR_W'(i), d, lat);
            chk("cleared_cell", 32'(d), 32'h0);
        end

        // Basic write then read with VGA address stable
        cpu_write(14'h0023, 8'hA5);
        step();
        cpu_read(14'h0023, d, lat);
        chk("rd_a5_data", 32'(d), 32'hA5);
        chk("rd_a5_within_2", 32'(lat <= 2), 32'd1);

        // 0x0123 is past the 64-cell tape: dropped, must not alias onto 0x23
        cpu_write(14'h0123, 8'h5C);
        step();
        cpu_read(14'h0023, d, lat);
        chk("oor_no_alias", 32'(d), 32'hA5);
        step();
        cpu_read(14'h0123, d, lat);
        chk("oor_read_zero", 32'(d), 32'h0);

        // VGA stepping 0,1,2 every 8 cycles
        cpu_write(14'h0000, 8'h10);
        cpu_write(14'h0001, 8'h20);
        cpu_write(14'h0002, 8'h30);
        step();
        for (int k = 0; k < 3; k++) begin
            vga_data_addr = ADDR_W'(k);
            step();
            chk("vga_step_lat1", 32'(vga_cell), 32'(exp_seq[k]));
            for (int j = 0; j < 7; j++) step();
            chk("vga_step_hold", 32'(vga_cell), 32'(exp_seq[k]));
        end

        // Coherence: write hits the displayed cell
        vga_data_addr = 14'h0005;
        step();
        step();
        chk("vga5_before", 32'(vga_cell), 32'h0);
        cpu_write(14'h0005, 8'h7E);
        chk("vga5_coherent", 32'(vga_cell), 32'h7E);
        step();
        cpu_read(14'h0005, d, lat);
        chk("rd5_after_write", 32'(d), 32'h7E);
        chk("vga5_still", 32'(vga_cell), 32'h7E);

        // Read starved by VGA churn for 4 cycles
        step();
        cpu_bus.cpu_addr = 14'h0023;
        cpu_bus.cpu_re   = 1'b1;
        rv = 0;
        for (int k = 6; k < 10; k++) begin
            vga_data_addr = ADDR_W'(k);
            step();
            if (cpu_bus.cpu_rvalid) rv++;
        end
        chk("churn_no_rvalid", 32'(rv), 32'd0);
        step();
        chk("churn_rvalid_after", 32'(cpu_bus.cpu_rvalid), 32'd1);
        chk("churn_rdata", 32'(cpu_bus.cpu_rdata), 32'hA5);
        cpu_bus.cpu_re = 1'b0;
        step();
        chk("rvalid_one_cycle", 32'(cpu_bus.cpu_rvalid), 32'd0);

        // Reset while a CPU read is pending behind a VGA fetch
        vga_data_addr  = 14'h000A;
        cpu_bus.cpu_addr = 14'h0023;
        cpu_bus.cpu_re = 1'b1;
        step();
        chk("pend_no_rvalid", 32'(cpu_bus.cpu_rvalid), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_rvalid", 32'(cpu_bus.cpu_rvalid), 32'd0);
        chk("midrst_ready",  32'(cpu_bus.cpu_ready), 32'd0);
        chk("midrst_vga_cell", 32'(vga_cell), 32'h0);
        wait_clear("reclear_cycles", n, rv);
        cpu_bus.cpu_re = 1'b0;
        chk("reclear_no_rvalid", 32'(rv), 32'd0);
        step();
        cpu_read(14'h0023, d, lat);
        chk("reclear_a5_gone", 32'(d), 32'h0);
        step();
        cpu_read(14'h0005, d, lat);
        chk("reclear_7e_gone", 32'(d), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
